// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, parity modes and default bit timing.
// Reused by the transmitter today and the receiver later.
package uart_pkg;

  localparam int CLKS_PER_BIT_DEF = 434;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  // Even mode makes the total number of ones even; odd mode inverts that bit.
  function automatic logic parity_of(input logic [7:0] b, input int mode);
    return (^b) ^ (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, wraps, and flags the last cycle.
// A synchronous clear holds it at zero.
module baud_tick #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr_i,
  output logic tick_o
);

  localparam int            W    = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0]  LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == LAST);

  always_comb begin
    // NOTE: a default assignment comes first so this block can never infer a latch.
    cnt_d = cnt_q + W'(1);
    if (clr_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, 1 or 2
// stop bits. A start in the final stop cycle chains the next frame with no gap.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int PARITY       = PAR_NONE,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy,
  output logic       ready,
  output logic       done,
  output logic       drop
);

  localparam logic HAS_PAR   = (PARITY != PAR_NONE);
  localparam logic LAST_STOP = (STOP_BITS == 2);

  tx_state_t  state_q;
  logic [7:0] shreg_q;
  logic       par_q;
  logic [2:0] idx_q;
  logic       stop_q;
  logic       tx_q, busy_q, drop_q;

  logic tick, last_stop, accept, timer_clr;

  // Every non-idle transition happens on the terminal count, where the timer
  // wraps to zero by itself; holding it clear in IDLE covers frame entry.
  assign timer_clr = (state_q == ST_IDLE);

  baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk   (clk),
    .rstn  (rstn),
    .clr_i (timer_clr),
    .tick_o(tick)
  );

  assign last_stop = (state_q == ST_STOP) && tick && (stop_q == LAST_STOP);
  assign ready     = (state_q == ST_IDLE) || last_stop;
  assign done      = last_stop;
  assign accept    = start && ready;

  assign tx   = tx_q;
  assign busy = busy_q;
  assign drop = drop_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      par_q   <= 1'b0;
      idx_q   <= '0;
      stop_q  <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      drop_q <= start && !ready;
      if (accept) begin
        // Same-cycle capture: the source changes data on the very next cycle.
        shreg_q <= data;
        par_q   <= parity_of(data, PARITY);
        idx_q   <= '0;
        stop_q  <= 1'b0;
        state_q <= ST_START;
        tx_q    <= 1'b0;
        busy_q  <= 1'b1;
      end else begin
        case (state_q)
          ST_IDLE: begin
            tx_q   <= 1'b1;
            busy_q <= 1'b0;
          end
          ST_START: begin
            if (tick) begin
              state_q <= ST_DATA;
              tx_q    <= shreg_q[0];
            end
          end
          ST_DATA: begin
            if (tick) begin
              if (idx_q == 3'd7) begin
                if (HAS_PAR) begin
                  state_q <= ST_PARITY;
                  tx_q    <= par_q;
                end else begin
                  state_q <= ST_STOP;
                  stop_q  <= 1'b0;
                  tx_q    <= 1'b1;
                end
              end else begin
                idx_q   <= idx_q + 3'd1;
                shreg_q <= {1'b0, shreg_q[7:1]};
                tx_q    <= shreg_q[1];
              end
            end
          end
          ST_PARITY: begin
            if (tick) begin
              state_q <= ST_STOP;
              stop_q  <= 1'b0;
              tx_q    <= 1'b1;
            end
          end
          ST_STOP: begin
            if (tick) begin
              if (stop_q == LAST_STOP) begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
              end else begin
                stop_q <= 1'b1;
              end
            end
          end
          default: begin
            state_q <= ST_IDLE;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter that consumes the `start`/`data` byte stream from the test-pattern source and drives the UART TX pin. It emits 8N1 frames by default, with optional parity and two stop bits, LSB first. Each frame is exactly 10 bit periods at default settings, so back-to-back bytes arriving every 10 bit periods are transmitted with no gap and no loss.

## Interface
- `CLKS_PER_BIT`, default 434: clk cycles per bit (50 MHz / 115200). Must be ≥ 2.
- `PARITY`, default 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, default 1: 1 or 2.
- `clk` input 1: clock, all state on rising edge.
- `rstn` input 1: asynchronous, active-low reset.
- `start` input 1: single-cycle request; `data` is sampled in the same cycle.
- `data` input 8: byte to send. Valid only in the cycle `start`=1.
- `tx` output 1: serial line, idle high.
- `busy` output 1: high while a frame is in progress. Low in IDLE.
- `ready` output 1: combinational. A `start` in this cycle will be accepted. High in IDLE and in the final cycle of the last stop bit.
- `done` output 1: one-cycle pulse in the final cycle of the last stop bit.
- `drop` output 1: one-cycle pulse, registered, the cycle after a `start` that arrives while `ready`=0.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - `tx`=1, `busy`=0.
  - On `start`: latch `data` into the shift register, clear the bit-timer and bit index, then go to START.
- START: `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
- DATA:
  - `tx` = `shreg[0]`. Shift right at the end of each bit period.
  - Send 8 bits, index 0..7.
  - After bit 7, go to PARITY if `PARITY`≠0, else go to STOP.
- PARITY:
  - `tx` = XOR of the latched byte for even, or its inverse for odd.
  - Parity is computed at latch time and held in its own flop.
  - After one bit period, go to STOP.
- STOP:
  - `tx`=1 for `STOP_BITS`×`CLKS_PER_BIT` cycles.
  - In the final cycle, `done`=1 and `ready`=1.
  - If `start`=1 in that final cycle, latch the new byte and go directly to START. `tx` goes low on the next cycle, so there is no idle gap.
  - Otherwise go to IDLE.
- Bit timer:
  - `$clog2(CLKS_PER_BIT)` bits wide. Counts 0..`CLKS_PER_BIT`−1, wraps, and is cleared on every state entry.
  - The stop-bit counter is a separate 1-bit count.
- `start` while `ready`=0: ignored. The frame in flight is unaffected and `drop` pulses.
- `data` is never sampled outside the accepting cycle. A byte that changes mid-frame has no effect.
- Reset values: `tx`=1, `busy`=0, `done`=0, `drop`=0, state=IDLE, shift register=0, counters=0.
- Reset mid-frame: `tx` returns to 1 asynchronously. The partial frame is abandoned, with no completion and no `done`.

## Timing
- `start` accepted at cycle T. Then:
  - `tx`=0 during cycles T+1..T+N, where N=`CLKS_PER_BIT`.
  - Data bit i is on the line during T+1+(i+1)N .. T+(i+2)N.
  - With 8N1: stop bit during T+1+9N..T+10N. `done` and `ready` high at T+10N.
- `busy` rises at T+1 and stays high through the final stop cycle. It stays continuously high across a back-to-back accept.
- Frame length: (10 + (`PARITY`≠0) + (`STOP_BITS`−1)) × N cycles.
- The source emits `start` every 10N cycles, which lands exactly on the final stop cycle. With 8N1 this gives 100% line utilisation and zero `drop`.
- The source increments `data` the cycle after `start`, so same-cycle sampling is mandatory.

## Structure
- Shared package `uart_pkg`:
  - State enum `tx_state_t`.
  - Parity-mode constants `PAR_NONE`/`PAR_EVEN`/`PAR_ODD`.
  - Default `CLKS_PER_BIT`=434.
  - These are reused by the future `uart_rx`.
- One natural sub-module: `baud_tick`, a parameterised bit-period counter with a synchronous clear and a terminal-count output. It is instantiated once here and later in `uart_rx`.
- All other logic lives in `uart_tx`.

## Test plan
- Reset release, then a single `start` with `data`=0xA5, N=434:
  - `tx` sequence per bit period is 0, 1,0,1,0,0,1,0,1, 1.
  - `done` at T+4340, `busy` falls at T+4341.
- Source-driven stream, `start` every 4340 cycles with `data` 0x00..0x0F:
  - 16 contiguous frames decode to the incrementing values.
  - `tx` is never high for more than N cycles between frames.
  - `drop` never fires.
- `start` at T+2000 during a frame: `drop` pulses at T+2001, the original byte completes unchanged, and no extra frame is sent.
- `PARITY`=1, `data`=0x07: parity bit is 1. With `PARITY`=2 it is 0. With `STOP_BITS`=2, `tx` is high for 2N cycles and `done` is at T+12N.
- `rstn` asserted at T+1500 (mid-DATA): `tx`=1 immediately. After release, a new `start` with 0x3C sends a clean frame.
- N=2 corner case: `data`=0xFF back-to-back on every `ready` cycle. Frames of 20 cycles each are received, and `busy` is continuously high.
